// File: rtl/anode_scan_driver.sv
// anode_scan_driver: drives an 8-digit common-anode seven-segment display.
// The asynchronous digit select is synchronised and debounced. Each accepted
// digit change is followed by an all-dark blank interval. Display data is
// double-buffered so that a newly loaded frame only takes effect when the scan
// next enters digit 0.
module anode_scan_driver #(
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  select,
   input  logic        load,
   input  logic [31:0] digits_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  enable_in,
   input  logic        lz_blank,
   output logic [7:0]  anode,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_start,
   output logic        pending
);

   localparam int CW = $clog2(BLANK_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [2:0]    s1, s2, s3;
   logic [2:0]    cur_digit;
   logic [CW-1:0] blank_cnt;
   logic          armed;
   logic          accept, commit;
   logic [31:0]   active_digits, pending_digits;
   logic [7:0]    active_dp, pending_dp;
   logic [7:0]    upper_zero;
   logic          lz_hit, lit;
   logic [3:0]    nibble;
   logic [7:0]    anode_nxt;
   logic [6:0]    seg_nxt;
   logic          dp_nxt;

   // Active-low g..a pattern for one hex digit
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      case (h)
         4'h0: hex_to_seg = 7'b1000000;
         4'h1: hex_to_seg = 7'b1111001;
         4'h2: hex_to_seg = 7'b0100100;
         4'h3: hex_to_seg = 7'b0110000;
         4'h4: hex_to_seg = 7'b0011001;
         4'h5: hex_to_seg = 7'b0010010;
         4'h6: hex_to_seg = 7'b0000010;
         4'h7: hex_to_seg = 7'b1111000;
         4'h8: hex_to_seg = 7'b0000000;
         4'h9: hex_to_seg = 7'b0010000;
         4'hA: hex_to_seg = 7'b0001000;
         4'hB: hex_to_seg = 7'b0000011;
         4'hC: hex_to_seg = 7'b1000110;
         4'hD: hex_to_seg = 7'b0100001;
         4'hE: hex_to_seg = 7'b0000110;
         default: hex_to_seg = 7'b0001110;
      endcase
   endfunction

   // A select value is taken only once it has been seen on two consecutive
   // synchronised samples, so a one-cycle glitch never reaches s2==s3.
   assign accept = (s2 == s3) && (s2 != cur_digit);
   assign commit = accept && (s2 == 3'd0) && pending;

   // Three-stage select synchroniser
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 3'd0;
         s2 <= 3'd0;
         s3 <= 3'd0;
      end else begin
         s1 <= select;
         s2 <= s2 == s2 ? s1 : s1;
         s3 <= s2;
      end
   end

   // Current digit, blank counter and the "seen a real digit" flag.
   // The flag keeps the display dark after reset until a genuine select
   // change has been accepted, since cur_digit=0 only mirrors reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_digit <= 3'd0;
         blank_cnt <= '0;
         armed     <= 1'b0;
      end else if (accept) begin
         cur_digit <= s2;
         blank_cnt <= '0;
         armed     <= 1'b1;
      end else if (state == ST_BLANK && blank_cnt != CNT_LAST) begin
         blank_cnt <= blank_cnt + 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_BLANK;
      else       state <= state_nxt;
   end

   // FSM next state: an acceptance always wins over leaving BLANK
   always_comb begin
      state_nxt = state;
      case (state)
         ST_BLANK: begin
            if (accept)                              state_nxt = ST_BLANK;
            else if (armed && blank_cnt == CNT_LAST) state_nxt = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (accept) state_nxt = ST_BLANK;
         end
         default: state_nxt = ST_BLANK;
      endcase
   end

   // Double buffer: commit copies the old pending frame before a same-cycle
   // load overwrites it, so the new load stays pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_digits  <= 32'd0;
         active_dp      <= 8'd0;
         pending_digits <= 32'd0;
         pending_dp     <= 8'd0;
         pending        <= 1'b0;
         frame_start    <= 1'b0;
      end else begin
         if (commit) begin
            active_digits <= pending_digits;
            active_dp     <= pending_dp;
         end
         if (load) begin
            pending_digits <= digits_in;
            pending_dp     <= dp_in;
         end
         if (load)        pending <= 1'b1;
         else if (commit) pending <= 1'b0;
         frame_start <= commit;
      end
   end

   // Leading-zero map: bit i set when nibbles i..7 of the active frame are all 0
   always_comb begin
      upper_zero = 8'd0;
      for (int i = 0; i < 8; i++)
         upper_zero[i] = ((active_digits >> (4 * i)) == 32'd0);
   end

   assign nibble = active_digits[{cur_digit, 2'b00} +: 4];
   assign lz_hit = lz_blank && (cur_digit != 3'd0) && upper_zero[cur_digit];
   assign lit    = enable_in[cur_digit] && !lz_hit;

   // FSM output decode (next values of the registered display drive)
   always_comb begin
      anode_nxt = 8'hFF;
      seg_nxt   = 7'h7F;
      dp_nxt    = 1'b1;
      if (state == ST_DRIVE && lit) begin
         anode_nxt = ~(8'd1 << cur_digit);
         seg_nxt   = hex_to_seg(nibble);
         dp_nxt    = ~active_dp[cur_digit];
      end
   end

   // Registered display drive; reset darkens it immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         anode <= 8'hFF;
         seg   <= 7'h7F;
         dp    <= 1'b1;
      end else begin
         anode <= anode_nxt;
         seg   <= seg_nxt;
         dp    <= dp_nxt;
      end
   end

endmodule
